clk_div_monitor: RTL
====================

// Module: clk_div_monitor
// PURPOSE
//  Receive-side companion to the clock dividers: takes a divided clock as a data signal, sampled
//  on clk_in, and measures its period and high time in clk_in cycles. Reports lock once the
//  period is stable, duty symmetry, and loss of clock (timeout).
//  Sits beside divider instances for self-check and bring-up, driven by the same clk_in.
// PARAMETERS
//  W           8    width of period/high_time counters and outputs
//  LOCK_CNT    4    consecutive identical periods required to assert locked (>=2)
//  MAX_PERIOD  255  cycles without a rising edge before err_timeout (< 2**W)
// PORTS
//  clk_in       in   1  system clock; all logic on posedge
//  rst_n        in   1  asynchronous active-low reset
//  clk_div      in   1  divided clock under test, treated as data, sampled on posedge clk_in
//  period       out  W  last measured period, in clk_in cycles
//  high_time    out  W  clk_in posedge samples with clk_div high in the last period
//  meas_valid   out  1  one-cycle pulse: period/high_time just updated
//  duty_ok      out  1  |2*high_time - period| <= 1 for the last measurement
//  locked       out  1  LOCK_CNT consecutive equal periods seen
//  err_timeout  out  1  no rising edge for MAX_PERIOD cycles
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE, counters 0. Reset mid-operation aborts any measurement.
//  - Sampling: s <= clk_div each posedge; s_q <= s. Rise = s & ~s_q. No other edge detection.
//  - Counters: on a rise, cnt <= 1 and hcnt <= 1. Otherwise cnt <= cnt+1, saturating at
//    MAX_PERIOD, and hcnt <= hcnt + s, saturating.
//  - FSM states IDLE, MEAS, LOCK:
//    IDLE: first rise -> MEAS. No meas_valid, because the first partial period is discarded.
//    MEAS/LOCK on a rise: period<=cnt, high_time<=hcnt, duty_ok<=(|2*hcnt-cnt|<=1), meas_valid<=1.
//      match = (cnt == previous period). match_cnt <= match ? match_cnt+1 : 1.
//      When match_cnt reaches LOCK_CNT, go to LOCK and set locked=1.
//      In LOCK, a mismatch -> MEAS, locked=0 the next cycle, and match_cnt restarts at 1.
//    MEAS/LOCK, cnt reaches MAX_PERIOD without a rise: err_timeout<=1, locked<=0, -> IDLE.
//      period, high_time and duty_ok keep their last values.
//  - err_timeout clears on the next rise. That rise only re-arms the FSM (IDLE->MEAS).
//  - Latency: the posedge that first samples clk_div=1 is N. The rise is detected at N+1.
//    meas_valid, period and high_time are registered there and visible through cycle N+2.
//  - clk_div held constant, high or low: no rises, so timeout after MAX_PERIOD cycles.
//  - Period of 1 cannot be represented; the minimum reported period is 2.
//    Periods > MAX_PERIOD are reported as timeout, never as a measurement.
//  - A rise in the same cycle that cnt hits MAX_PERIOD: the rise wins. It is a measurement
//    with period = MAX_PERIOD, and there is no timeout.
//  - meas_valid is never high for two consecutive cycles.
// TESTING
//  1. Drive from odd_clk_divider N=5, clk_in 10ns, rst_n release at 25ns.
//     -> first meas_valid after the 2nd rise. period=5, high_time in {2,3}, duty_ok=1.
//     locked=1 after 4 equal periods.
//  2. Even divider N=4 -> period=4, high_time=2, duty_ok=1, locked after 4 measurements.
//  3. Switch the divider from 5 to 7 while locked -> the next measurement gives period=7.
//     locked=0 the cycle after, then re-locks 3 periods later.
//  4. Hold clk_div=0 while locked -> err_timeout=1 and locked=0, 255 cycles after the last
//     rise. Restart the clock -> err_timeout clears on the 1st rise, first new meas_valid
//     on the 2nd rise.
//  5. Pulse waveform: 1 cycle high, 5 low (period 6) -> high_time=1, duty_ok=0, locked still
//     asserted after 4 periods.
//  6. Assert rst_n=0 mid-period while locked -> all outputs 0 immediately (asynchronous).
//     After release, the first rise gives no meas_valid.

Source files
------------

// File: rtl/clk_div_monitor_if.sv
// Result bus of the divided-clock monitor: the clock under test going in and the
// measurement outputs coming back.
interface clk_div_monitor_if #(
    parameter int W = 8
);
    logic         clk_div;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         duty_ok;
    logic         locked;
    logic         err_timeout;

    modport master (
        input  clk_div,
        output period, high_time, meas_valid, duty_ok, locked, err_timeout
    );

    modport slave (
        output clk_div,
        input  period, high_time, meas_valid, duty_ok, locked, err_timeout
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled as data on clk_in, and
// reports measurement pulses, duty symmetry, frequency lock and loss of clock.
module clk_div_monitor #(
    parameter int W          = 8,
    parameter int LOCK_CNT   = 4,
    parameter int MAX_PERIOD = 255
) (
    input  logic              clk_in,
    input  logic              rst_n,
    clk_div_monitor_if.master mon
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0]  MAX_P    = W'(MAX_PERIOD);
    localparam logic [W-1:0]  ONE      = W'(1);
    localparam logic [MW-1:0] M_ONE    = MW'(1);
    localparam logic [MW-1:0] M_LOCK   = MW'(LOCK_CNT);
    localparam logic [W+1:0]  DIFF_ONE = (W+2)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_LOCK
    } state_t;

    state_t         state_q, state_d;
    logic           samp_q, samp_dly_q;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   hcnt_q, hcnt_d;
    logic [MW-1:0]  match_cnt_q, match_cnt_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   high_time_q, high_time_d;
    logic           meas_valid_q, meas_valid_d;
    logic           duty_ok_q, duty_ok_d;
    logic           locked_q, locked_d;
    logic           err_timeout_q, err_timeout_d;

    logic           rise;
    logic [W+1:0]   diff;
    logic [W+1:0]   diff_abs;
    logic           duty_calc;

    // Two-flop sample of the clock under test; a rise is one cycle after the first high sample.
    assign rise = samp_q & ~samp_dly_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves a latch.
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = ONE;
            hcnt_d = ONE;
        end else begin
            if (cnt_q != MAX_P) cnt_d = cnt_q + ONE;
            if (samp_q && hcnt_q != MAX_P) hcnt_d = hcnt_q + ONE;
        end
    end

    // Signed difference 2*high - period, widened by two bits so neither term overflows.
    always_comb begin
        diff      = {1'b0, hcnt_q, 1'b0} - {2'b00, cnt_q};
        diff_abs  = diff[W+1] ? (~diff + DIFF_ONE) : diff;
        duty_calc = (diff_abs <= DIFF_ONE);
    end

    always_comb begin
        state_d       = state_q;
        match_cnt_d   = match_cnt_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        meas_valid_d  = 1'b0;
        duty_ok_d     = duty_ok_q;
        locked_d      = locked_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            ST_IDLE: begin
                // The partial period before the first rise is discarded: arm only.
                if (rise) begin
                    state_d       = ST_MEAS;
                    err_timeout_d = 1'b0;
                    match_cnt_d   = '0;
                end
            end
            ST_MEAS, ST_LOCK: begin
                if (rise) begin
                    period_d     = cnt_q;
                    high_time_d  = hcnt_q;
                    duty_ok_d    = duty_calc;
                    meas_valid_d = 1'b1;
                    if (cnt_q == period_q) begin
                        if (match_cnt_q != M_LOCK) match_cnt_d = match_cnt_q + M_ONE;
                    end else begin
                        match_cnt_d = M_ONE;
                    end
                    if (match_cnt_d >= M_LOCK) begin
                        state_d  = ST_LOCK;
                        locked_d = 1'b1;
                    end else begin
                        state_d  = ST_MEAS;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q == MAX_P) begin
                    state_d       = ST_IDLE;
                    err_timeout_d = 1'b1;
                    locked_d      = 1'b0;
                    match_cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            samp_q        <= 1'b0;
            samp_dly_q    <= 1'b0;
            cnt_q         <= '0;
            hcnt_q        <= '0;
            match_cnt_q   <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            meas_valid_q  <= 1'b0;
            duty_ok_q     <= 1'b0;
            locked_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_q        <= mon.clk_div;
            samp_dly_q    <= samp_q;
            cnt_q         <= cnt_d;
            hcnt_q        <= hcnt_d;
            match_cnt_q   <= match_cnt_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            meas_valid_q  <= meas_valid_d;
            duty_ok_q     <= duty_ok_d;
            locked_q      <= locked_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign mon.period      = period_q;
    assign mon.high_time   = high_time_q;
    assign mon.meas_valid  = meas_valid_q;
    assign mon.duty_ok     = duty_ok_q;
    assign mon.locked      = locked_q;
    assign mon.err_timeout = err_timeout_q;

endmodule
